// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants, state encoding and address packing for the feature RAM master
// Contents: bus geometry constants, FSM state type, pack_addr() helper.
package ram_pkg;

  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 1024;
  localparam int PT_BITS    = $clog2(DEPTH);
  localparam int LENGTH     = 16;
  localparam int LEN_BITS   = $clog2(LENGTH);

  localparam logic [LEN_BITS-1:0] LAST_FEAT = LEN_BITS'(LENGTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // RAM word address of one feature of one data point.
  function automatic logic [ADDR_WIDTH-1:0] pack_addr(input logic [PT_BITS-1:0]  point,
                                                      input logic [LEN_BITS-1:0] feat);
    return {point, feat};
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - read-return tracker: valid/last delay line plus read-data capture register
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req, req_last  a read request is on the bus this cycle / it is the burst's final feature
//   bus_data       RAM data bus (sampled READ_LAT edges after the request)
//   rd_valid       registered one-cycle pulse per returned word
//   rd_last        with rd_valid: final word of the burst
//   rd_data        captured word
//   drain_done     no request will still be in flight after this edge
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  req_last,
  input  logic [DATA_WIDTH-1:0] bus_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  drain_done
);

  logic [READ_LAT-1:0] vld_sr;
  logic [READ_LAT-1:0] last_sr;

  // Stage READ_LAT-1 holds the request whose data is on the bus this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr   <= '0;
      last_sr  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      vld_sr[0]  <= req;
      last_sr[0] <= req & req_last;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
      rd_valid <= vld_sr[READ_LAT-1];
      rd_last  <= vld_sr[READ_LAT-1] & last_sr[READ_LAT-1];
      if (vld_sr[READ_LAT-1]) begin
        rd_data <= bus_data;
      end
    end
  end

  // Only the final stage may still be occupied: it is consumed at this edge.
  logic pending;
  always_comb begin
    pending = req;
    for (int i = 0; i < READ_LAT - 1; i++) begin
      pending = pending | vld_sr[i];
    end
    drain_done = ~pending;
  end

endmodule

// File: rtl/ram_vector_master.sv
// rtl/ram_vector_master.sv - burst bus initiator moving whole feature vectors to/from the feature RAM
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cmd_valid/cmd_ready              command handshake; cmd_write selects burst direction, cmd_point the vector
//   wr_valid/wr_ready/wr_data        write-word stream, features 0..LENGTH-1
//   rd_valid/rd_data/rd_last         read-word pulses, no backpressure
//   busy                             any state other than IDLE
//   ram_cs/ram_we/ram_oe/ram_addr    registered RAM bus controls
//   ram_data                         shared data bus, driven by this block only while ram_oe==0
module ram_vector_master
  import ram_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [PT_BITS-1:0]    cmd_point,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  state_t                state_q, state_n;
  logic [LEN_BITS-1:0]   feat_q, feat_n;
  logic [PT_BITS-1:0]    point_q, point_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic                  cs_n, we_n, oe_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic                  drain_done;

  assign ram_data = ram_oe ? {DATA_WIDTH{1'bz}} : wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      feat_q    <= '0;
      point_q   <= '0;
      wdata_q   <= '0;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      busy      <= 1'b0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b1;
      ram_addr  <= '0;
    end else begin
      state_q   <= state_n;
      feat_q    <= feat_n;
      point_q   <= point_n;
      wdata_q   <= wdata_n;
      cmd_ready <= (state_n == ST_IDLE);
      wr_ready  <= (state_n == ST_WRITE);
      busy      <= (state_n != ST_IDLE);
      ram_cs    <= cs_n;
      ram_we    <= we_n;
      ram_oe    <= oe_n;
      ram_addr  <= addr_n;
    end
  end

  // Bus outputs are computed one cycle ahead and registered. In READ, feat_q is
  // the feature whose request is on the bus this cycle; in WRITE it is the next
  // feature to be written.
  always_comb begin
    state_n = state_q;
    feat_n  = feat_q;
    point_n = point_q;
    wdata_n = wdata_q;
    cs_n    = 1'b0;
    we_n    = 1'b0;
    oe_n    = 1'b1;
    addr_n  = ram_addr;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          point_n = cmd_point;
          feat_n  = '0;
          if (cmd_write) begin
            state_n = ST_WRITE;
          end else begin
            // First read request goes out in the first READ cycle.
            state_n = ST_READ;
            cs_n    = 1'b1;
            addr_n  = pack_addr(cmd_point, '0);
          end
        end
      end

      ST_WRITE: begin
        if (wr_valid && wr_ready) begin
          cs_n    = 1'b1;
          we_n    = 1'b1;
          oe_n    = 1'b0;
          addr_n  = pack_addr(point_q, feat_q);
          wdata_n = wr_data;
          feat_n  = feat_q + 1'b1;
          // The last bus cycle is presented during the first IDLE cycle.
          if (feat_q == LAST_FEAT) begin
            state_n = ST_IDLE;
          end
        end
      end

      ST_READ: begin
        if (feat_q == LAST_FEAT) begin
          state_n = ST_DRAIN;
        end else begin
          feat_n = feat_q + 1'b1;
          cs_n   = 1'b1;
          addr_n = pack_addr(point_q, feat_q + 1'b1);
        end
      end

      ST_DRAIN: begin
        if (drain_done) begin
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  ram_rd_pipe #(
    .READ_LAT(READ_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .req       (ram_cs & ~ram_we),
    .req_last  ((state_q == ST_READ) && (feat_q == LAST_FEAT)),
    .bus_data  (ram_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .rd_data   (rd_data),
    .drain_done(drain_done)
  );

endmodule

// File: tb/tb_ram_vector_master.sv
// tb/tb_ram_vector_master.sv - scoreboard bench for ram_vector_master with a RAM model on the shared bus
module tb_ram_vector_master;
  import ram_pkg::*;

  localparam int READ_LAT = 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic                  cmd_write = 1'b0;
  logic [PT_BITS-1:0]    cmd_point = '0;
  logic                  wr_valid = 1'b0;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data = '0;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  busy;
  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;
  logic [ADDR_WIDTH-1:0] ram_addr;
  wire  [DATA_WIDTH-1:0] ram_data;

  always #5 clk = ~clk;

  ram_vector_master #(.READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_point(cmd_point),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  // RAM model: one-edge read latency, drives the bus only in the data cycle.
  logic [DATA_WIDTH-1:0] ram_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] ram_q = '0;
  logic                  ram_drv = 1'b0;
  assign ram_data = ram_drv ? ram_q : {DATA_WIDTH{1'bz}};

  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;
    if (ram_cs && !ram_we) begin
      ram_q   <= ram_mem[ram_addr];
      ram_drv <= 1'b1;
    end else begin
      ram_drv <= 1'b0;
    end
  end

  // Reference model: what every vector should hold.
  logic [DATA_WIDTH-1:0] ref_mem [0:DEPTH-1][0:LENGTH-1];

  typedef struct { logic [DATA_WIDTH-1:0] data; logic last; logic first; } rd_exp_t;
  typedef struct { logic [ADDR_WIDTH-1:0] addr; logic [DATA_WIDTH-1:0] data; } wr_exp_t;
  rd_exp_t exp_rd[$];
  wr_exp_t exp_wr[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int req0_cyc = 0;
  int contention = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_drv && !ram_oe) contention++;
      if (ram_cs && !ram_we && ram_addr % LENGTH == 0) req0_cyc = cyc;
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          check("rd_unexpected", rd_valid, 0);
        end else begin
          rd_exp_t e;
          e = exp_rd.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_last", rd_last, e.last);
          if (e.first) check("rd_latency", cyc - req0_cyc, READ_LAT + 1);
        end
      end else if (rd_last) begin
        check("rd_last_without_valid", rd_last, 0);
      end
      if (ram_cs && ram_we) begin
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", ram_we, 0);
        end else begin
          wr_exp_t w;
          w = exp_wr.pop_front();
          check("wr_addr", ram_addr, w.addr);
          check("wr_data", ram_data, w.data);
          check("wr_oe", ram_oe, 0);
        end
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ram_cs", ram_cs, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_oe", ram_oe, 1);
    check("rst_ram_addr", ram_addr, 0);
  endtask

  task automatic issue_cmd(input logic wr, input int pt);
    int g = 0;
    while (!cmd_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_point = PT_BITS'(pt);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // mode 0: wr_valid held, 1: toggling, 2: random. rnd selects random data.
  task automatic do_write(input int pt, input int mode, input logic [DATA_WIDTH-1:0] base, input bit rnd);
    int i = 0;
    int g = 0;
    logic v;
    logic [DATA_WIDTH-1:0] d;
    issue_cmd(1'b1, pt);
    d = rnd ? DATA_WIDTH'($urandom) : base;
    while (i < LENGTH && g < 500) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 2 == 0) : 1'($urandom_range(0, 1));
      wr_valid = v;
      wr_data  = d;
      if (v && wr_ready) begin
        exp_wr.push_back('{addr: ADDR_WIDTH'(pt * LENGTH + i), data: d});
        ref_mem[pt][i] = d;
        i++;
        d = rnd ? DATA_WIDTH'($urandom) : base + DATA_WIDTH'(i);
      end
      @(posedge clk);
      @(negedge clk);
      g++;
    end
    wr_valid = 1'b0;
    if (i < LENGTH) check("wr_burst_timeout", i, LENGTH);
  endtask

  task automatic push_read(input int pt);
    for (int i = 0; i < LENGTH; i++)
      exp_rd.push_back('{data: ref_mem[pt][i], last: (i == LENGTH - 1), first: (i == 0)});
  endtask

  task automatic do_read(input int pt);
    int g = 0;
    push_read(pt);
    issue_cmd(1'b0, pt);
    // Stray write words must be ignored outside WRITE.
    while (exp_rd.size() != 0 && g < 200) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = DATA_WIDTH'($urandom);
      @(negedge clk);
      g++;
    end
    wr_valid = 1'b0;
    if (exp_rd.size() != 0) check("rd_burst_timeout", exp_rd.size(), 0);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!cmd_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!cmd_ready) check("idle_timeout", cmd_ready, 1);
    @(negedge clk);
  endtask

  task automatic reset_mid_clock();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals();
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_WIDTH); a++) ram_mem[a] = '0;
    for (int p = 0; p < DEPTH; p++)
      for (int f = 0; f < LENGTH; f++) ref_mem[p][f] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    // Reset asserted mid-clock while a read burst is in progress.
    issue_cmd(1'b0, 5);
    reset_mid_clock();
    repeat (4) @(negedge clk);

    // Write point 3 with wr_valid held, then check RAM contents.
    do_write(3, 0, 32'hA000_0000, 1'b0);
    wait_idle();
    for (int i = 0; i < LENGTH; i++)
      check("ram_contents_pt3", ram_mem[3 * LENGTH + i], 32'hA000_0000 + i);

    // Read point 3.
    do_read(3);

    // Point 1023 with toggling wr_valid, read back.
    do_write(1023, 1, '0, 1'b1);
    wait_idle();
    do_read(1023);

    // Write immediately followed by read of the same point.
    do_write(7, 2, '0, 1'b1);
    do_read(7);

    // Reset in the middle of a read burst, then read again.
    push_read(3);
    issue_cmd(1'b0, 3);
    repeat (7) @(negedge clk);
    reset_mid_clock();
    repeat (6) @(negedge clk);
    do_read(3);

    // Randomized mix of commands.
    for (int n = 0; n < 40; n++) begin
      int pt;
      int sel;
      sel = $urandom_range(0, 3);
      pt = (sel == 0) ? 3 : (sel == 1) ? 1023 : (sel == 2) ? 0 : int'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) do_write(pt, int'($urandom_range(0, 2)), '0, 1'b1);
      else do_read(pt);
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("bus_contention", contention, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
